fxp_div_seq: RTL and testbench

- Parametrised sequential restoring divider with integrated controller, successor to the fixed 10-bit fraction divider datapath.
- Computes Q = trunc(A*2^FRAC / B) and the matching remainder, in unsigned or two's-complement mode selected per operation.
- Uses a start/busy/done handshake and flags divide-by-zero and overflow, with saturation on overflow.
- Sits beside the other arithmetic units as a self-contained multicycle operator, so no external controller is needed.

---
 rtl/fxp_div_if.sv | 29 ++
 rtl/fxp_div_seq.sv | 186 ++++++++++++++++++
 tb/tb_fxp_div_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fxp_div_if.sv
// fxp_div_if: handshake and operand/result bundle for the sequential
// fixed-point divider.
//   start, signed_mode, a_in, b_in : request side (driven by the master)
//   busy, done, q_out, r_out       : status and results (driven by the slave)
//   dvz, ovf                       : divide-by-zero and overflow flags
interface fxp_div_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             dvz;
  logic             ovf;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, done, q_out, r_out, dvz, ovf
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, done, q_out, r_out, dvz, ovf
  );
endinterface

// File: rtl/fxp_div_seq.sv
// fxp_div_seq: sequential restoring divider, Q = trunc(A*2^FRAC / B),
// unsigned or two's complement per operation, with saturation on overflow.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fxp_div_if.slave: start/signed_mode/a_in/b_in in,
//          busy/done/q_out/r_out/dvz/ovf out
// One quotient bit per clock; done pulses WIDTH+FRAC+2 edges after the
// accepting edge (counting that edge), or on the accepting edge for b==0.
module fxp_div_seq #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic      clk,
  input  logic      rst,
  fxp_div_if.slave  bus
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  // Quotient-magnitude limits, one bit wider than the raw quotient so the
  // signed negative limit 2^(WIDTH-1) compares cleanly.
  localparam logic [N:0] UMAX = {{(FRAC + 1){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [N:0] SPOS = UMAX >> 1;
  localparam logic [N:0] SNEG = SPOS + 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    iter;
  logic             smode;
  logic             sq;
  logic             sr;
  logic [WIDTH-1:0] bmag;
  logic [N-1:0]     shreg;
  // Partial remainder is always < |B|, so WIDTH bits suffice between
  // iterations; the extra bit only exists in the shifted value p_shift.
  logic [WIDTH-1:0] prem;
  logic [N-1:0]     quot;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             dvz_r;
  logic             ovf_r;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    sa;
  logic                    sb;
  logic [WIDTH-1:0]        amag;
  logic [WIDTH:0]          p_shift;
  logic                    p_ge;
  logic                    ovf_c;
  logic                    last_iter;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  function automatic logic ovf_chk(input logic [N-1:0] m, input logic sm,
                                   input logic neg);
    logic [N:0] mm;
    mm = {1'b0, m};
    if (!sm)
      return mm > UMAX;
    else if (neg)
      return mm > SNEG;
    else
      return mm > SPOS;
  endfunction

  // Saturate on overflow, otherwise apply the quotient sign.
  function automatic logic [WIDTH-1:0] sat_q(input logic [N-1:0] m,
                                             input logic sm, input logic neg,
                                             input logic ov);
    if (ov) begin
      if (!sm)
        return {WIDTH{1'b1}};
      else if (neg)
        return {1'b1, {(WIDTH - 1){1'b0}}};
      else
        return {1'b0, {(WIDTH - 1){1'b1}}};
    end
    return neg ? WIDTH'(-m[WIDTH-1:0]) : m[WIDTH-1:0];
  endfunction

  // Operand conditioning (used only on the accepting edge)
  assign a_s  = bus.a_in;
  assign b_s  = bus.b_in;
  assign sa   = bus.signed_mode & (a_s < 0);
  assign sb   = bus.signed_mode & (b_s < 0);
  assign amag = abs_val(bus.a_in, sa);

  // Iteration core
  assign p_shift   = {prem, shreg[N-1]};
  assign p_ge      = p_shift >= {1'b0, bmag};
  assign last_iter = (iter == CW'(N - 1));
  assign ovf_c     = ovf_chk(quot, smode, sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = (bus.b_in == '0) ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter  <= '0;
      smode <= 1'b0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      bmag  <= '0;
      shreg <= '0;
      prem  <= '0;
      quot  <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dvz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        // Accept: latch conditioned operands, clear flags
        S_IDLE: begin
          if (bus.start) begin
            smode <= bus.signed_mode;
            sq    <= sa ^ sb;
            sr    <= sa;
            bmag  <= abs_val(bus.b_in, sb);
            shreg <= N'(amag) << FRAC;
            prem  <= '0;
            quot  <= '0;
            iter  <= '0;
            ovf_r <= 1'b0;
            dvz_r <= 1'b0;
            if (bus.b_in == '0) begin
              q_r   <= '0;
              r_r   <= '0;
              dvz_r <= 1'b1;
            end
          end
        end
        // One restoring step per clock
        S_CALC: begin
          shreg <= shreg << 1;
          quot  <= (quot << 1) | N'(p_ge);
          prem  <= p_ge ? WIDTH'(p_shift - {1'b0, bmag}) : p_shift[WIDTH-1:0];
          iter  <= iter + 1'b1;
        end
        // Sign fixup and saturation, results published on entry to DONE
        S_FIN: begin
          ovf_r <= ovf_c;
          q_r   <= sat_q(quot, smode, sq, ovf_c);
          r_r   <= sr ? WIDTH'(-prem) : prem;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == S_CALC) || (state == S_FIN);
  assign bus.done  = (state == S_DONE);
  assign bus.q_out = q_r;
  assign bus.r_out = r_r;
  assign bus.dvz   = dvz_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb_fxp_div_seq: directed-vector bench for fxp_div_seq (WIDTH=10, FRAC=4).
module tb_fxp_div_seq;

  localparam int WIDTH = 10;
  localparam int FRAC  = 4;

  logic clk;
  logic rst;

  fxp_div_if #(.WIDTH(WIDTH)) bus ();

  fxp_div_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int lat;
  int bcnt;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply start for one edge, then count edges until done (bounded).
  // lat counts the accepting edge as 1; bcnt counts sampled busy cycles.
  task automatic run_op(input logic sm, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.a_in        = a;
    bus.b_in        = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no done within 40 edges");
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_q", 32'(bus.q_out), 0);
    check_eq("rst_r", 32'(bus.r_out), 0);
    check_eq("rst_flags", {30'b0, bus.dvz, bus.ovf}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned 7/2: 112/2 = 56 r 0
    run_op(1'b0, 10'd7, 10'd2);
    check_eq("u7_2_lat", lat, 16);
    check_eq("u7_2_busy", bcnt, 15);
    check_eq("u7_2_q", 32'(bus.q_out), 32'h038);
    check_eq("u7_2_r", 32'(bus.r_out), 0);
    check_eq("u7_2_flags", {30'b0, bus.dvz, bus.ovf}, 0);
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(bus.done), 0);

    // Unsigned 10/3: 160/3 = 53 r 1
    run_op(1'b0, 10'd10, 10'd3);
    check_eq("u10_3_q", 32'(bus.q_out), 32'h035);
    check_eq("u10_3_r", 32'(bus.r_out), 1);
    @(posedge clk); #1;

    // Unsigned 1000/2: 8000 > 1023 -> saturate
    run_op(1'b0, 10'd1000, 10'd2);
    check_eq("u1000_ovf", 32'(bus.ovf), 1);
    check_eq("u1000_q", 32'(bus.q_out), 32'h3FF);
    check_eq("u1000_r", 32'(bus.r_out), 0);
    @(posedge clk); #1;

    // Divide by zero
    run_op(1'b0, 10'd5, 10'd0);
    check_eq("dvz_lat", lat, 1);
    check_eq("dvz_busy", bcnt, 0);
    check_eq("dvz_busy_now", 32'(bus.busy), 0);
    check_eq("dvz_flag", 32'(bus.dvz), 1);
    check_eq("dvz_ovf", 32'(bus.ovf), 0);
    check_eq("dvz_q", 32'(bus.q_out), 0);
    check_eq("dvz_r", 32'(bus.r_out), 0);
    @(posedge clk); #1;
    run_op(1'b0, 10'd7, 10'd2);
    check_eq("dvz_clr", 32'(bus.dvz), 0);
    check_eq("dvz_next_q", 32'(bus.q_out), 32'h038);
    @(posedge clk); #1;

    // Signed -10/3: q = -53, r = -1
    run_op(1'b1, 10'h3F6, 10'd3);
    check_eq("s_m10_3_q", 32'(bus.q_out), 32'h3CB);
    check_eq("s_m10_3_r", 32'(bus.r_out), 32'h3FF);
    check_eq("s_m10_3_ovf", 32'(bus.ovf), 0);
    @(posedge clk); #1;

    // Signed 100/-1: -1600 < -512 -> saturate to min
    run_op(1'b1, 10'd100, 10'h3FF);
    check_eq("s_100_m1_ovf", 32'(bus.ovf), 1);
    check_eq("s_100_m1_q", 32'(bus.q_out), 32'h200);
    @(posedge clk); #1;

    // Start with new operands mid-CALC is ignored
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.a_in        = 10'd7;
    bus.b_in        = 10'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a_in  = 10'd100;
    bus.b_in  = 10'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 7;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("ign_lat", lat, 16);
    check_eq("ign_q", 32'(bus.q_out), 32'h038);
    // Start raised during the DONE cycle must be ignored
    bus.start = 1'b1;
    bus.a_in  = 10'd10;
    bus.b_in  = 10'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("b2b_busy", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_q", 32'(bus.q_out), 32'h038);
    check_eq("hold_done", 32'(bus.done), 0);

    // Asynchronous reset mid-CALC
    bus.start = 1'b1;
    bus.a_in  = 10'd7;
    bus.b_in  = 10'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 0);
    check_eq("arst_done", 32'(bus.done), 0);
    check_eq("arst_q", 32'(bus.q_out), 0);
    check_eq("arst_r", 32'(bus.r_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 10'd10, 10'd3);
    check_eq("arst_next_lat", lat, 16);
    check_eq("arst_next_q", 32'(bus.q_out), 32'h035);
    check_eq("arst_next_r", 32'(bus.r_out), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
